// File: rtl/wb_mm_pkg.sv
// Shared types and constants for the multi-master Wishbone controller.
package wb_mm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } wb_mm_state_t;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

endpackage

// File: rtl/wb_multi_master_ctrl_if.sv
// Wishbone B4 classic master-side bus bundle of the multi-master controller.
interface wb_multi_master_ctrl_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();
  logic [AW-1:0]   wb_adr_o;
  logic [DW-1:0]   wb_dat_o;
  logic [DW/8-1:0] wb_sel_o;
  logic            wb_we_o;
  logic            wb_cyc_o;
  logic            wb_stb_o;
  logic [DW-1:0]   wb_dat_i;
  logic            wb_ack_i;
  logic            wb_err_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/wb_mm_arbiter.sv
// One-hot requester selection (fixed priority or round-robin) with the
// registered round-robin pointer, advanced only when a grant is issued.
module wb_mm_arbiter
  import wb_mm_pkg::*;
#(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ARB_MODE  = ARB_RR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] req_i,
  input  logic                 adv_i,
  output logic [N_MASTERS-1:0] gnt_o
);
  localparam int unsigned PW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;
  int unsigned   start;

  // Two passes: indices at/after the pointer first, then the wrapped ones.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    start = (ARB_MODE == ARB_RR) ? 32'(ptr_q) : 0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      if (!found && k >= start && req_i[k]) begin
        gnt_o[k] = 1'b1;
        ptr_d    = PW'((k + 1) % N_MASTERS);
        found    = 1'b1;
      end
    end
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      if (!found && k < start && req_i[k]) begin
        gnt_o[k] = 1'b1;
        ptr_d    = PW'((k + 1) % N_MASTERS);
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        ptr_q <= '0;
    else if (adv_i) ptr_q <= ptr_d;
  end
endmodule

// File: rtl/wb_multi_master_ctrl.sv
// N-requester Wishbone B4 classic master with registered arbitration and bus
// cycle. Optional bus watchdog enabled by defining WB_MM_TIMEOUT_EN.
module wb_multi_master_ctrl
  import wb_mm_pkg::*;
#(
  parameter int unsigned N_MASTERS      = 2,
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned ARB_MODE       = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_MASTERS-1:0]        req_i,
  input  logic [N_MASTERS-1:0]        we_i,
  input  logic [N_MASTERS*AW-1:0]     adr_i,
  input  logic [N_MASTERS*DW-1:0]     dat_i,
  input  logic [N_MASTERS*DW/8-1:0]   sel_i,
  output logic [DW-1:0]               rdata_o,
  output logic [N_MASTERS-1:0]        ack_o,
  output logic [N_MASTERS-1:0]        err_o,
  output logic [N_MASTERS-1:0]        grant_o,
  output logic                        timeout_o,
  wb_multi_master_ctrl_if.master      wb
);
  localparam int unsigned SW = DW / 8;

  if (N_MASTERS < 1 || N_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("wb_multi_master_ctrl: unsupported parameter set");
  end

  wb_mm_state_t          state_q, state_d;
  logic [N_MASTERS-1:0]  grant_q, grant_d, ack_q, ack_d, err_q, err_d;
  logic [N_MASTERS-1:0]  arb_gnt;
  logic                  arb_adv;
  logic [DW-1:0]         rdata_q, rdata_d, dat_q, dat_d, win_dat;
  logic [AW-1:0]         adr_q, adr_d, win_adr;
  logic [SW-1:0]         sel_q, sel_d, win_sel;
  logic                  we_q, we_d, win_we, cyc_q, cyc_d;

  wb_mm_arbiter #(
    .N_MASTERS (N_MASTERS),
    .ARB_MODE  (ARB_MODE)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (req_i),
    .adv_i (arb_adv),
    .gnt_o (arb_gnt)
  );

  always_comb begin
    win_adr = '0;
    win_dat = '0;
    win_sel = '0;
    win_we  = 1'b0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      if (arb_gnt[k]) begin
        win_adr = adr_i[k*AW +: AW];
        win_dat = dat_i[k*DW +: DW];
        win_sel = sel_i[k*SW +: SW];
        win_we  = we_i[k];
      end
    end
  end

`ifdef WB_MM_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ack_d   = '0;
    err_d   = '0;
    rdata_d = rdata_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    cyc_d   = cyc_q;
    arb_adv = 1'b0;
`ifdef WB_MM_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          arb_adv = 1'b1;
          grant_d = arb_gnt;
          adr_d   = win_adr;
          dat_d   = win_dat;
          sel_d   = win_sel;
          we_d    = win_we;
          cyc_d   = 1'b1;
          state_d = BUS;
`ifdef WB_MM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUS: begin
        // Error takes precedence over a simultaneous ack and leaves rdata alone.
        if (wb.wb_err_i) begin
          err_d   = grant_q;
          cyc_d   = 1'b0;
          state_d = DONE;
        end else if (wb.wb_ack_i) begin
          ack_d   = grant_q;
          if (!we_q) rdata_d = wb.wb_dat_i;
          cyc_d   = 1'b0;
          state_d = DONE;
        end
`ifdef WB_MM_TIMEOUT_EN
        else if (cnt_q == TMO_LAST) begin
          err_d   = grant_q;
          tmo_d   = 1'b1;
          cyc_d   = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
`endif
      end
      DONE: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
`ifdef WB_MM_TIMEOUT_EN
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
`ifdef WB_MM_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

`ifdef WB_MM_TIMEOUT_EN
  assign timeout_o = tmo_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign rdata_o     = rdata_q;
  assign ack_o       = ack_q;
  assign err_o       = err_q;
  assign grant_o     = grant_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_sel_o = sel_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = cyc_q;
endmodule

// File: tb/tb_wb_multi_master_ctrl.sv
// Directed self-checking bench for wb_multi_master_ctrl (2-master and 3-master builds).
module tb_wb_multi_master_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Two-master instance with a bench-driven slave
  logic [1:0]  req_a = '0, we_a = '0;
  logic [63:0] adr_a = '0, dat_a = '0;
  logic [7:0]  sel_a = '0;
  logic [31:0] rdata_a;
  logic [1:0]  ack_a, err_a, grant_a;
  logic        tmo_a;
  logic        a_ack = 1'b0, a_err = 1'b0;
  logic [31:0] a_dat = '0;

  wb_multi_master_ctrl_if #(.AW(32), .DW(32)) a_if ();
  assign a_if.wb_ack_i = a_ack;
  assign a_if.wb_err_i = a_err;
  assign a_if.wb_dat_i = a_dat;

  wb_multi_master_ctrl #(
    .N_MASTERS(2), .AW(32), .DW(32), .ARB_MODE(1), .TIMEOUT_CYCLES(8)
  ) dut_a (
    .clk(clk), .rst(rst), .req_i(req_a), .we_i(we_a), .adr_i(adr_a),
    .dat_i(dat_a), .sel_i(sel_a), .rdata_o(rdata_a), .ack_o(ack_a),
    .err_o(err_a), .grant_o(grant_a), .timeout_o(tmo_a), .wb(a_if)
  );

  // Three-master instances (round-robin and fixed) with zero-wait slaves
  logic [2:0]  req3 = '0, we3 = '0;
  logic [95:0] adr3 = '0, dat3 = '0;
  logic [11:0] sel3 = '0;
  logic [31:0] rdata_rr, rdata_fp;
  logic [2:0]  ack_rr, err_rr, grant_rr, ack_fp, err_fp, grant_fp;
  logic        tmo_rr, tmo_fp;

  wb_multi_master_ctrl_if #(.AW(32), .DW(32)) rr_if ();
  wb_multi_master_ctrl_if #(.AW(32), .DW(32)) fp_if ();
  assign rr_if.wb_ack_i = rr_if.wb_cyc_o;
  assign rr_if.wb_err_i = 1'b0;
  assign rr_if.wb_dat_i = 32'h0;
  assign fp_if.wb_ack_i = fp_if.wb_cyc_o;
  assign fp_if.wb_err_i = 1'b0;
  assign fp_if.wb_dat_i = 32'h0;

  wb_multi_master_ctrl #(
    .N_MASTERS(3), .AW(32), .DW(32), .ARB_MODE(1), .TIMEOUT_CYCLES(8)
  ) dut_rr (
    .clk(clk), .rst(rst), .req_i(req3), .we_i(we3), .adr_i(adr3),
    .dat_i(dat3), .sel_i(sel3), .rdata_o(rdata_rr), .ack_o(ack_rr),
    .err_o(err_rr), .grant_o(grant_rr), .timeout_o(tmo_rr), .wb(rr_if)
  );

  wb_multi_master_ctrl #(
    .N_MASTERS(3), .AW(32), .DW(32), .ARB_MODE(0), .TIMEOUT_CYCLES(8)
  ) dut_fp (
    .clk(clk), .rst(rst), .req_i(req3), .we_i(we3), .adr_i(adr3),
    .dat_i(dat3), .sel_i(sel3), .rdata_o(rdata_fp), .ack_o(ack_fp),
    .err_o(err_fp), .grant_o(grant_fp), .timeout_o(tmo_fp), .wb(fp_if)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (a_if.wb_cyc_o !== 1'b0 || a_if.wb_stb_o !== 1'b0) begin errors++; $display("FAIL rst_cyc: got cyc=%b stb=%b want 0", a_if.wb_cyc_o, a_if.wb_stb_o); end
    checks++; if (grant_a !== 2'b00 || ack_a !== 2'b00 || err_a !== 2'b00) begin errors++; $display("FAIL rst_gae: got grant=%b ack=%b err=%b want 0", grant_a, ack_a, err_a); end
    checks++; if (rdata_a !== 32'h0 || a_if.wb_adr_o !== 32'h0 || tmo_a !== 1'b0) begin errors++; $display("FAIL rst_data: got rdata=%h adr=%h tmo=%b want 0", rdata_a, a_if.wb_adr_o, tmo_a); end
    checks++; if (grant_rr !== 3'b000 || grant_fp !== 3'b000 || rr_if.wb_cyc_o !== 1'b0) begin errors++; $display("FAIL rst_n3: got grant_rr=%b grant_fp=%b cyc=%b want 0", grant_rr, grant_fp, rr_if.wb_cyc_o); end
    rst = 1'b0;
  endtask

  task automatic test_read_zero_wait();
    a_ack = 1'b1;  // ack present while idle must be ignored
    a_dat = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (a_if.wb_cyc_o !== 1'b0) begin errors++; $display("FAIL t1_idle_ack: got cyc=%b want 0", a_if.wb_cyc_o); end
    req_a = 2'b01; we_a = 2'b00; adr_a[31:0] = 32'h0000_1000;
    @(posedge clk);  // cycle 0: request sampled
    @(negedge clk);  // cycle 1
    checks++; if (a_if.wb_cyc_o !== 1'b1 || a_if.wb_stb_o !== 1'b1) begin errors++; $display("FAIL t1_cyc: got cyc=%b stb=%b want 1", a_if.wb_cyc_o, a_if.wb_stb_o); end
    checks++; if (a_if.wb_adr_o !== 32'h1000 || grant_a !== 2'b01 || a_if.wb_we_o !== 1'b0) begin errors++; $display("FAIL t1_bus: got adr=%h grant=%b we=%b want 1000 01 0", a_if.wb_adr_o, grant_a, a_if.wb_we_o); end
    checks++; if (ack_a !== 2'b00) begin errors++; $display("FAIL t1_early_ack: got %b want 00", ack_a); end
    @(posedge clk);
    @(negedge clk);  // cycle 2
    checks++; if (ack_a !== 2'b01 || rdata_a !== 32'hDEADBEEF) begin errors++; $display("FAIL t1_ack: got ack=%b rdata=%h want 01 deadbeef", ack_a, rdata_a); end
    checks++; if (a_if.wb_cyc_o !== 1'b0 || grant_a !== 2'b01) begin errors++; $display("FAIL t1_done: got cyc=%b grant=%b want 0 01", a_if.wb_cyc_o, grant_a); end
    req_a = 2'b00; a_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (ack_a !== 2'b00 || grant_a !== 2'b00) begin errors++; $display("FAIL t1_after: got ack=%b grant=%b want 00 00", ack_a, grant_a); end
  endtask

  task automatic test_arbitration();
    logic [2:0] exp_rr [4];
    bit         seen;
    exp_rr = '{3'b001, 3'b010, 3'b100, 3'b001};
    @(negedge clk);
    req3 = 3'b111;
    for (int t = 0; t < 4; t++) begin
      seen = 1'b0;
      for (int w = 0; w < 8 && !seen; w++) begin
        @(negedge clk);
        if (rr_if.wb_cyc_o === 1'b1) seen = 1'b1;
      end
      checks++; if (!seen) begin errors++; $display("FAIL t2_timeout_%0d: got no cyc within 8 cycles want cyc", t); end
      checks++; if (grant_rr !== exp_rr[t]) begin errors++; $display("FAIL t2_rr_%0d: got %b want %b", t, grant_rr, exp_rr[t]); end
      checks++; if (grant_fp !== 3'b001) begin errors++; $display("FAIL t2_fp_%0d: got %b want 001", t, grant_fp); end
      @(posedge clk);
    end
    req3 = 3'b000;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_write_wait();
    logic [31:0] hold_adr;
    @(negedge clk);
    req_a = 2'b10; we_a = 2'b10;
    adr_a[63:32] = 32'h0000_2004; dat_a[63:32] = 32'h55AA00FF; sel_a[7:4] = 4'b0011;
    a_dat = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    hold_adr = a_if.wb_adr_o;
    checks++; if (a_if.wb_adr_o !== 32'h2004 || a_if.wb_dat_o !== 32'h55AA00FF || a_if.wb_sel_o !== 4'b0011 || a_if.wb_we_o !== 1'b1) begin errors++; $display("FAIL t3_bus: got adr=%h dat=%h sel=%b we=%b want 2004 55aa00ff 0011 1", a_if.wb_adr_o, a_if.wb_dat_o, a_if.wb_sel_o, a_if.wb_we_o); end
    checks++; if (grant_a !== 2'b10) begin errors++; $display("FAIL t3_grant: got %b want 10", grant_a); end
    req_a = 2'b00; adr_a[63:32] = 32'hFFFF_0000; dat_a[63:32] = 32'h0;  // must be ignored
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      checks++; if (a_if.wb_cyc_o !== 1'b1 || a_if.wb_adr_o !== hold_adr || a_if.wb_dat_o !== 32'h55AA00FF || a_if.wb_sel_o !== 4'b0011 || ack_a !== 2'b00) begin errors++; $display("FAIL t3_stable_%0d: got cyc=%b adr=%h dat=%h sel=%b ack=%b want 1 2004 55aa00ff 0011 00", c, a_if.wb_cyc_o, a_if.wb_adr_o, a_if.wb_dat_o, a_if.wb_sel_o, ack_a); end
    end
    a_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_ack = 1'b0;
    checks++; if (ack_a !== 2'b10 || err_a !== 2'b00 || rdata_a !== 32'hDEADBEEF) begin errors++; $display("FAIL t3_ack: got ack=%b err=%b rdata=%h want 10 00 deadbeef", ack_a, err_a, rdata_a); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (ack_a !== 2'b00 || rdata_a !== 32'hDEADBEEF) begin errors++; $display("FAIL t3_pulse: got ack=%b rdata=%h want 00 deadbeef", ack_a, rdata_a); end
    we_a = 2'b00;
  endtask

  task automatic test_ack_err_together();
    @(negedge clk);
    req_a = 2'b01; adr_a[31:0] = 32'h0000_0040;
    a_ack = 1'b1; a_err = 1'b1; a_dat = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    checks++; if (a_if.wb_cyc_o !== 1'b1) begin errors++; $display("FAIL t4_cyc: got %b want 1", a_if.wb_cyc_o); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (err_a !== 2'b01 || ack_a !== 2'b00 || rdata_a !== 32'hDEADBEEF) begin errors++; $display("FAIL t4_err: got err=%b ack=%b rdata=%h want 01 00 deadbeef", err_a, ack_a, rdata_a); end
    req_a = 2'b00; a_ack = 1'b0; a_err = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (err_a !== 2'b00) begin errors++; $display("FAIL t4_pulse: got %b want 00", err_a); end
  endtask

  task automatic test_reset_in_bus();
    @(negedge clk);
    req_a = 2'b01; adr_a[31:0] = 32'h0000_3000;
    @(posedge clk);
    @(negedge clk);
    checks++; if (grant_a !== 2'b01 || a_if.wb_cyc_o !== 1'b1) begin errors++; $display("FAIL t5_pre: got grant=%b cyc=%b want 01 1", grant_a, a_if.wb_cyc_o); end
    rst = 1'b1; req_a = 2'b11;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (a_if.wb_cyc_o !== 1'b0 || a_if.wb_stb_o !== 1'b0 || grant_a !== 2'b00 || ack_a !== 2'b00 || err_a !== 2'b00) begin errors++; $display("FAIL t5_rst: got cyc=%b stb=%b grant=%b ack=%b err=%b want all 0", a_if.wb_cyc_o, a_if.wb_stb_o, grant_a, ack_a, err_a); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (grant_a !== 2'b01 || a_if.wb_cyc_o !== 1'b1 || a_if.wb_adr_o !== 32'h3000) begin errors++; $display("FAIL t5_ptr: got grant=%b cyc=%b adr=%h want 01 1 3000", grant_a, a_if.wb_cyc_o, a_if.wb_adr_o); end
    req_a = 2'b00; a_ack = 1'b1; a_dat = 32'h0BADF00D;
    @(posedge clk);
    @(negedge clk);
    a_ack = 1'b0;
    checks++; if (ack_a !== 2'b01 || rdata_a !== 32'h0BADF00D) begin errors++; $display("FAIL t5_after: got ack=%b rdata=%h want 01 0badf00d", ack_a, rdata_a); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (grant_a !== 2'b00) begin errors++; $display("FAIL t5_idle: got %b want 00", grant_a); end
  endtask

`ifdef WB_MM_TIMEOUT_EN
  task automatic test_timeout();
    @(negedge clk);
    req_a = 2'b01; adr_a[31:0] = 32'h0000_5000;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checks++; if (a_if.wb_cyc_o !== 1'b1 || tmo_a !== 1'b0 || err_a !== 2'b00) begin errors++; $display("FAIL t6_bus_%0d: got cyc=%b tmo=%b err=%b want 1 0 00", c, a_if.wb_cyc_o, tmo_a, err_a); end
      @(posedge clk);
    end
    @(negedge clk);
    checks++; if (a_if.wb_cyc_o !== 1'b0 || err_a !== 2'b01 || tmo_a !== 1'b1) begin errors++; $display("FAIL t6_expire: got cyc=%b err=%b tmo=%b want 0 01 1", a_if.wb_cyc_o, err_a, tmo_a); end
    req_a = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (tmo_a !== 1'b1 || err_a !== 2'b00) begin errors++; $display("FAIL t6_sticky: got tmo=%b err=%b want 1 00", tmo_a, err_a); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (tmo_a !== 1'b0) begin errors++; $display("FAIL t6_clear: got %b want 0", tmo_a); end
  endtask
`else
  task automatic test_no_timeout();
    @(negedge clk);
    req_a = 2'b01; adr_a[31:0] = 32'h0000_5000;
    @(posedge clk);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++; if (a_if.wb_cyc_o !== 1'b1 || tmo_a !== 1'b0 || err_a !== 2'b00) begin errors++; $display("FAIL t6_wait: got cyc=%b tmo=%b err=%b want 1 0 00", a_if.wb_cyc_o, tmo_a, err_a); end
    req_a = 2'b00; a_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_ack = 1'b0;
    checks++; if (ack_a !== 2'b01) begin errors++; $display("FAIL t6_ack: got %b want 01", ack_a); end
  endtask
`endif

  initial begin
    test_reset();
    test_read_zero_wait();
    test_arbitration();
    test_write_wait();
    test_ack_err_together();
    test_reset_in_bus();
`ifdef WB_MM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
